soil_sensor_acq: RTL and testbench
==================================

SOIL_SENSOR_ACQ -- requirements
Module: soil_sensor_acq

Interface
REQ-001 Parameter CLK_DIV, default 4, clk cycles per SCLK half-period; legal range 3..255.
REQ-002 Parameter SAMPLE_PERIOD, default 1000, clk cycles between scan ticks; legal minimum 64.
REQ-003 Parameter SETTLE_CYC, default 8, clk cycles of mux settling before each conversion.
REQ-004 Parameter AVG_LOG2, default 2, log2 of conversions averaged per output; legal range 0..3.
REQ-005 clk  in  1  single clock domain for the whole block.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 ena  in  1  enables scan start; sampled only in IDLE.
REQ-008 clr_i  in  1  one-cycle pulse that clears the overrun flag.
REQ-009 adc_cs_n  out  1  ADC chip select, active-low.
REQ-010 adc_sclk  out  1  ADC serial clock, idles low.
REQ-011 adc_miso  in  1  ADC serial data, asynchronous to clk.
REQ-012 ch_sel  out  1  analog mux select: 0 = moisture, 1 = temperature.
REQ-013 sample_o  out  8  averaged sample.
REQ-014 sample_ch_o  out  1  channel of sample_o.
REQ-015 sample_valid_o  out  1  sample_o and sample_ch_o are valid.
REQ-016 sample_ready_i  in  1  consumer accepts the sample.
REQ-017 busy_o  out  1  high whenever the FSM is not in IDLE.
REQ-018 overrun_o  out  1  sticky flag: an unaccepted sample was overwritten.

Function
REQ-019 The period timer shall free-run and emit a one-cycle tick every SAMPLE_PERIOD clk cycles.
REQ-020 A tick while FSM=IDLE and ena=1 shall start a scan: channel 0, then channel 1.
REQ-021 A tick while not in IDLE shall be dropped and not queued.
REQ-022 The FSM shall have states IDLE -> SETTLE -> CONV -> ACC, followed by SETTLE for the next channel or IDLE when the scan completes.
REQ-023 SETTLE shall drive ch_sel to the current channel, hold adc_cs_n high, and last exactly SETTLE_CYC cycles.
REQ-024 CONV shall drive adc_cs_n low for exactly 9 SCLK periods.
REQ-025 Each SCLK period shall be 2*CLK_DIV clk cycles, with the rising edge in the middle of the period.
REQ-026 Bit 1 of the frame is the null bit and shall be discarded.
REQ-027 Bits 2..9 shall be shifted in MSB first at the internal SCLK rising edge.
REQ-028 adc_miso shall pass through a 2-flop synchronizer before it is used.
REQ-029 adc_cs_n shall return high in the cycle CONV exits.
REQ-030 ACC shall take one cycle and add the 8-bit result to that channel's accumulator; each accumulator is 8+AVG_LOG2 bits wide.
REQ-031 After 2^AVG_LOG2 conversions of a channel, the block shall load sample_o with the accumulator shifted right by AVG_LOG2 (truncating) and clear that accumulator.
REQ-032 sample_valid_o shall rise in the cycle after ACC.
REQ-033 A sample is transferred when valid=1 and ready=1 on the same edge; valid shall drop the next cycle unless a new sample loads on that same edge.
REQ-034 If a new sample loads while valid=1 and ready=0, the new sample shall overwrite the old one and overrun_o shall set.
REQ-035 If clr_i and an overrun event occur in the same cycle, overrun_o shall be set.
REQ-036 If ena falls mid-scan, the current scan shall complete and the FSM shall then remain in IDLE.

Reset
REQ-037 When rst is asserted, the following shall take effect immediately, with no clk edge required: FSM=IDLE, adc_cs_n=1, adc_sclk=0, ch_sel=0, sample_o=0, sample_ch_o=0, sample_valid_o=0, busy_o=0, overrun_o=0.
REQ-038 Reset shall also clear the accumulators, conversion counts, period timer, and synchronizer.
REQ-039 Reset asserted mid-conversion shall abort the frame with no partial sample output.

Structure
REQ-040 A shared package shall hold the FSM state enum, the channel encodings (moisture=0, temperature=1), and the 9-bit frame length constant.
REQ-041 The SPI frame engine shall be one sub-module, adc_spi_rx, with inputs start and miso, outputs cs_n, sclk, data[7:0] and done, and parameter CLK_DIV.

Verification
REQ-042 AVG_LOG2=0; ADC model returns 0xA5 on ch0 and 0x3C on ch1; ready=1 -> outputs (ch0, 0xA5) then (ch1, 0x3C); each frame has 9 SCLK rising edges with CS low.
REQ-043 AVG_LOG2=2; ch0 conversions 10, 11, 12, 13 -> a single output 0x0B; four conversions of 0xFF -> 0xFF with no wrap.
REQ-044 ready=0 across two scans -> overrun_o=1 and sample_o holds the latest value; a clr_i pulse -> overrun_o=0.
REQ-045 rst asserted during bit 5 of CONV -> adc_cs_n=1 and adc_sclk=0 before the next clk edge; no sample_valid_o afterward; after release the next tick starts a clean scan.
REQ-046 ena dropped during ch0 SETTLE -> ch1 still converts, then busy_o=0 and no further frames appear across 3 SAMPLE_PERIODs.

Source files
------------

// File: rtl/soil_sensor_acq_pkg.sv
// Shared definitions for the soil sensor acquisition block.
//   acq_state_t    : scan FSM states
//   CH_MOISTURE    : analog mux code for the moisture probe
//   CH_TEMPERATURE : analog mux code for the temperature probe
//   FRAME_BITS     : SCLK periods per ADC frame (null bit + 8 data bits)
package soil_sensor_acq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CONV   = 2'd2,
        ST_ACC    = 2'd3
    } acq_state_t;

    localparam logic CH_MOISTURE    = 1'b0;
    localparam logic CH_TEMPERATURE = 1'b1;

    localparam int FRAME_BITS = 9;

endpackage

// File: rtl/adc_spi_rx.sv
// Serial frame receiver for an 8-bit ADC with one leading null bit.
// Ports:
//   clk, rst : block clock, asynchronous active-high reset
//   start    : one-cycle request to run one frame (ignored while active)
//   miso     : already-synchronized serial data from the ADC
//   cs_n     : chip select, low for exactly FRAME_BITS SCLK periods
//   sclk     : serial clock, low half then high half of each period
//   data     : last received byte, valid from the cycle done is high
//   done     : one-cycle pulse, coincides with cs_n returning high
module adc_spi_rx
    import soil_sensor_acq_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       miso,
    output logic       cs_n,
    output logic       sclk,
    output logic [7:0] data,
    output logic       done
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

    logic       active_reg;
    logic [7:0] div_cnt_reg;
    logic [3:0] bit_cnt_reg;
    logic       sclk_reg;
    logic       cs_n_reg;
    logic       done_reg;
    logic [7:0] shift_reg;
    logic [7:0] data_reg;
    logic       half_end;

    assign half_end = active_reg && (div_cnt_reg == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_reg  <= 1'b0;
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            sclk_reg    <= 1'b0;
            cs_n_reg    <= 1'b1;
            done_reg    <= 1'b0;
            shift_reg   <= '0;
            data_reg    <= '0;
        end else begin
            done_reg <= 1'b0;
            if (!active_reg) begin
                if (start) begin
                    active_reg  <= 1'b1;
                    cs_n_reg    <= 1'b0;
                    div_cnt_reg <= '0;
                    bit_cnt_reg <= '0;
                end
            end else if (half_end) begin
                div_cnt_reg <= '0;
                sclk_reg    <= ~sclk_reg;
                if (!sclk_reg) begin
                    // Rising edge: period 0 carries the null bit, skip it.
                    if (bit_cnt_reg != 4'd0) begin
                        shift_reg <= {shift_reg[6:0], miso};
                    end
                end else if (bit_cnt_reg == BIT_LAST) begin
                    // Falling edge that closes the last period ends the frame.
                    active_reg <= 1'b0;
                    cs_n_reg   <= 1'b1;
                    done_reg   <= 1'b1;
                    data_reg   <= shift_reg;
                end else begin
                    bit_cnt_reg <= bit_cnt_reg + 4'd1;
                end
            end else begin
                div_cnt_reg <= div_cnt_reg + 8'd1;
            end
        end
    end

    assign cs_n = cs_n_reg;
    assign sclk = sclk_reg;
    assign data = data_reg;
    assign done = done_reg;

endmodule

// File: rtl/soil_sensor_acq.sv
// Periodic two-channel soil sensor acquisition with per-channel averaging.
// Ports:
//   clk, rst        : block clock, asynchronous active-high reset
//   ena             : allows a scan to start on a period tick
//   clr_i           : pulse clearing the sticky overrun flag
//   adc_cs_n/sclk   : ADC serial interface outputs
//   adc_miso        : ADC serial data (asynchronous, synchronized here)
//   ch_sel          : analog mux select (0 moisture, 1 temperature)
//   sample_o/ch_o   : averaged sample and its channel
//   sample_valid_o  : sample handshake valid
//   sample_ready_i  : sample handshake ready
//   busy_o          : scan in progress
//   overrun_o       : an unaccepted sample was overwritten
module soil_sensor_acq
    import soil_sensor_acq_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int SETTLE_CYC    = 8,
    parameter int AVG_LOG2      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       clr_i,
    output logic       adc_cs_n,
    output logic       adc_sclk,
    input  logic       adc_miso,
    output logic       ch_sel,
    output logic [7:0] sample_o,
    output logic       sample_ch_o,
    output logic       sample_valid_o,
    input  logic       sample_ready_i,
    output logic       busy_o,
    output logic       overrun_o
);

    localparam int ACC_W = 8 + AVG_LOG2;
    localparam int TMR_W = $clog2(SAMPLE_PERIOD);
    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [3:0]       CNT_LAST = 4'((1 << AVG_LOG2) - 1);

    acq_state_t state_reg, state_next;
    logic             miso_meta_reg, miso_sync_reg;
    logic [TMR_W-1:0] timer_reg;
    logic             tick;
    logic [SET_W-1:0] settle_cnt_reg;
    logic             ch_reg;
    logic             spi_start, spi_done;
    logic [7:0]       spi_data;
    logic [1:0][ACC_W-1:0] acc_sum;
    logic [1:0]       acc_last;
    logic             load;
    logic [7:0]       sample_reg;
    logic             sample_ch_reg, valid_reg, overrun_reg;

    // Two-flop synchronizer for the asynchronous ADC data line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso_meta_reg <= 1'b0;
            miso_sync_reg <= 1'b0;
        end else begin
            miso_meta_reg <= adc_miso;
            miso_sync_reg <= miso_meta_reg;
        end
    end

    // Free-running period timer; the tick is the last count of each period.
    assign tick = (timer_reg == TMR_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_reg <= '0;
        end else if (tick) begin
            timer_reg <= '0;
        end else begin
            timer_reg <= timer_reg + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Ticks outside IDLE fall through unhandled, so they are dropped.
    always_comb begin
        state_next = state_reg;
        spi_start  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (tick && ena) begin
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_reg == SET_LAST) begin
                    spi_start  = 1'b1;
                    state_next = ST_CONV;
                end
            end
            ST_CONV: begin
                if (spi_done) begin
                    state_next = ST_ACC;
                end
            end
            ST_ACC: begin
                state_next = (ch_reg == CH_TEMPERATURE) ? ST_IDLE : ST_SETTLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Channel pointer and settle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_reg         <= CH_MOISTURE;
            settle_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    ch_reg         <= CH_MOISTURE;
                    settle_cnt_reg <= '0;
                end
                ST_SETTLE: begin
                    settle_cnt_reg <= (settle_cnt_reg == SET_LAST) ? '0
                                                                  : settle_cnt_reg + SET_W'(1);
                end
                ST_ACC: begin
                    settle_cnt_reg <= '0;
                    if (ch_reg == CH_MOISTURE) begin
                        ch_reg <= CH_TEMPERATURE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    adc_spi_rx #(
        .CLK_DIV (CLK_DIV)
    ) u_spi (
        .clk   (clk),
        .rst   (rst),
        .start (spi_start),
        .miso  (miso_sync_reg),
        .cs_n  (adc_cs_n),
        .sclk  (adc_sclk),
        .data  (spi_data),
        .done  (spi_done)
    );

    // Per-channel accumulators. The sum including the current conversion is
    // exposed so the averaged output can be taken in the same ACC cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        logic [ACC_W-1:0] acc_reg;
        logic [3:0]       conv_cnt_reg;
        logic             hit;

        assign hit          = (state_reg == ST_ACC) && (ch_reg == 1'(gi));
        assign acc_sum[gi]  = acc_reg + ACC_W'(spi_data);
        assign acc_last[gi] = (conv_cnt_reg == CNT_LAST);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc_reg      <= '0;
                conv_cnt_reg <= '0;
            end else if (hit) begin
                if (acc_last[gi]) begin
                    acc_reg      <= '0;
                    conv_cnt_reg <= '0;
                end else begin
                    acc_reg      <= acc_sum[gi];
                    conv_cnt_reg <= conv_cnt_reg + 4'd1;
                end
            end
        end
    end

    assign load = (state_reg == ST_ACC) && acc_last[ch_reg];

    // Output register: a new load always wins; an overwrite of an
    // unaccepted sample sets overrun, which also wins over clr_i.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_reg    <= '0;
            sample_ch_reg <= 1'b0;
            valid_reg     <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            if (load) begin
                sample_reg    <= 8'(acc_sum[ch_reg] >> AVG_LOG2);
                sample_ch_reg <= ch_reg;
                valid_reg     <= 1'b1;
            end else if (sample_ready_i) begin
                valid_reg <= 1'b0;
            end
            if (load && valid_reg && !sample_ready_i) begin
                overrun_reg <= 1'b1;
            end else if (clr_i) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign ch_sel         = ch_reg;
    assign sample_o       = sample_reg;
    assign sample_ch_o    = sample_ch_reg;
    assign sample_valid_o = valid_reg;
    assign busy_o         = (state_reg != ST_IDLE);
    assign overrun_o      = overrun_reg;

endmodule

// File: tb/tb_soil_sensor_acq.sv
// Directed bench for soil_sensor_acq. Instance A averages nothing (AVG_LOG2=0),
// instance B averages four conversions (AVG_LOG2=2). Each has a small ADC
// model that shifts its frame out on falling SCLK after a leading null bit.
module tb_soil_sensor_acq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A ----------------
    logic rst_a = 1'b1, ena_a = 1'b0, clr_a = 1'b0, ready_a = 1'b0, miso_a = 1'b0;
    logic cs_n_a, sclk_a, ch_sel_a, ch_a, valid_a, busy_a, ovr_a;
    logic [7:0] sample_a;

    soil_sensor_acq #(
        .CLK_DIV(4), .SAMPLE_PERIOD(200), .SETTLE_CYC(4), .AVG_LOG2(0)
    ) dut_a (
        .clk(clk), .rst(rst_a), .ena(ena_a), .clr_i(clr_a),
        .adc_cs_n(cs_n_a), .adc_sclk(sclk_a), .adc_miso(miso_a),
        .ch_sel(ch_sel_a), .sample_o(sample_a), .sample_ch_o(ch_a),
        .sample_valid_o(valid_a), .sample_ready_i(ready_a),
        .busy_o(busy_a), .overrun_o(ovr_a)
    );

    // ---------------- instance B ----------------
    logic rst_b = 1'b1, ena_b = 1'b0, clr_b = 1'b0, ready_b = 1'b1, miso_b = 1'b0;
    logic cs_n_b, sclk_b, ch_sel_b, ch_b, valid_b, busy_b, ovr_b;
    logic [7:0] sample_b;

    soil_sensor_acq #(
        .CLK_DIV(4), .SAMPLE_PERIOD(200), .SETTLE_CYC(4), .AVG_LOG2(2)
    ) dut_b (
        .clk(clk), .rst(rst_b), .ena(ena_b), .clr_i(clr_b),
        .adc_cs_n(cs_n_b), .adc_sclk(sclk_b), .adc_miso(miso_b),
        .ch_sel(ch_sel_b), .sample_o(sample_b), .sample_ch_o(ch_b),
        .sample_valid_o(valid_b), .sample_ready_i(ready_b),
        .busy_o(busy_b), .overrun_o(ovr_b)
    );

    // ---------------- ADC models / monitors (sampled on falling clk) ----------------
    logic [7:0] frame_a, frame_b;
    logic [7:0] val_b0 = 8'd0, val_b1 = 8'd0;
    logic cs_a_q = 1'b1, sclk_a_q = 1'b0, cs_b_q = 1'b1, sclk_b_q = 1'b0;
    int rise_a = 0, fall_a = 0, rises_last_a = 0, frames_a = 0, valid_cnt_a = 0;
    int fall_b = 0, xfer_b = 0;
    logic [7:0] cap_d  [8];
    logic       cap_ch [8];

    always @(negedge clk) begin
        if (cs_a_q && !cs_n_a) begin
            frame_a  = ch_sel_a ? 8'h3C : 8'hA5;
            rise_a   = 0;
            fall_a   = 0;
            miso_a   = 1'b0;
            frames_a = frames_a + 1;
        end else if (!cs_n_a) begin
            if (!sclk_a_q && sclk_a) rise_a = rise_a + 1;
            if (sclk_a_q && !sclk_a) begin
                fall_a = fall_a + 1;
                if (fall_a <= 8) miso_a = frame_a[8 - fall_a];
            end
        end
        if (!cs_a_q && cs_n_a) rises_last_a = rise_a;
        if (valid_a === 1'b1) valid_cnt_a = valid_cnt_a + 1;
        cs_a_q   = cs_n_a;
        sclk_a_q = sclk_a;
    end

    always @(negedge clk) begin
        if (cs_b_q && !cs_n_b) begin
            frame_b = ch_sel_b ? val_b1 : val_b0;
            fall_b  = 0;
            miso_b  = 1'b0;
        end else if (!cs_n_b && sclk_b_q && !sclk_b) begin
            fall_b = fall_b + 1;
            if (fall_b <= 8) miso_b = frame_b[8 - fall_b];
        end
        if (valid_b === 1'b1 && ready_b && xfer_b < 8) begin
            cap_d[xfer_b]  = sample_b;
            cap_ch[xfer_b] = ch_b;
            xfer_b = xfer_b + 1;
        end
        cs_b_q   = cs_n_b;
        sclk_b_q = sclk_b;
    end

    // ---------------- checking helpers ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig_of(input int sel);
        case (sel)
            0:       return busy_a;
            1:       return valid_a;
            2:       return busy_b;
            3:       return (cs_n_a == 1'b0) && (rise_a == 5);
            4:       return (ch_a == 1'b0);
            default: return 1'b0;
        endcase
    endfunction

    // Bounded wait at falling edges; an expired bound shows up as a failed check.
    task automatic wait_for(input int sel, input logic lvl, input int budget, input string tag);
        int n = 0;
        while (sig_of(sel) !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(sig_of(sel)), 32'(lvl));
    endtask

    int snap;

    initial begin
        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst_cs_n",    32'(cs_n_a),   32'd1);
        chk("rst_sclk",    32'(sclk_a),   32'd0);
        chk("rst_ch_sel",  32'(ch_sel_a), 32'd0);
        chk("rst_sample",  32'(sample_a), 32'd0);
        chk("rst_ch",      32'(ch_a),     32'd0);
        chk("rst_valid",   32'(valid_a),  32'd0);
        chk("rst_busy",    32'(busy_a),   32'd0);
        chk("rst_overrun", 32'(ovr_a),    32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        ena_a = 1'b1;
        ready_a = 1'b1;

        // ---- A: single conversions, ch0 then ch1 ----
        wait_for(1, 1'b1, 500, "a_valid0_wait");
        chk("a_ch0",      32'(ch_a),     32'd0);
        chk("a_data0",    32'(sample_a), 32'hA5);
        chk("a_rises0",   32'(rises_last_a), 32'd9);
        chk("a_busy_mid", 32'(busy_a),   32'd1);
        @(negedge clk);
        chk("a_valid_drop", 32'(valid_a), 32'd0);
        wait_for(1, 1'b1, 300, "a_valid1_wait");
        chk("a_ch1",    32'(ch_a),     32'd1);
        chk("a_data1",  32'(sample_a), 32'h3C);
        chk("a_rises1", 32'(rises_last_a), 32'd9);
        @(negedge clk);
        ready_a = 1'b0;
        chk("a_valid_drop1", 32'(valid_a), 32'd0);

        // ---- A: overrun across two scans with ready low ----
        wait_for(0, 1'b1, 500, "ovr_scan1_start");
        wait_for(0, 1'b0, 500, "ovr_scan1_end");
        wait_for(0, 1'b1, 500, "ovr_scan2_start");
        wait_for(0, 1'b0, 500, "ovr_scan2_end");
        chk("ovr_flag",   32'(ovr_a),    32'd1);
        chk("ovr_valid",  32'(valid_a),  32'd1);
        chk("ovr_latest", 32'(sample_a), 32'h3C);
        chk("ovr_ch",     32'(ch_a),     32'd1);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        chk("clr_flag",  32'(ovr_a),   32'd0);
        chk("clr_valid", 32'(valid_a), 32'd1);

        // ---- A: clear coinciding with an overrun event keeps the flag set ----
        clr_a = 1'b1;
        wait_for(4, 1'b1, 500, "clr_coll_wait");
        clr_a = 1'b0;
        chk("clr_coll_flag", 32'(ovr_a),    32'd1);
        chk("clr_coll_data", 32'(sample_a), 32'hA5);
        wait_for(0, 1'b0, 300, "clr_coll_end");
        ready_a = 1'b1;
        @(negedge clk);
        chk("drain_valid", 32'(valid_a), 32'd0);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        chk("drain_ovr", 32'(ovr_a), 32'd0);

        // ---- A: ena dropped during ch0 settle ----
        wait_for(0, 1'b1, 500, "ena_scan_start");
        ena_a = 1'b0;
        snap = frames_a;
        wait_for(0, 1'b0, 500, "ena_scan_end");
        chk("ena_frames", 32'(frames_a - snap), 32'd2);
        repeat (600) @(negedge clk);
        chk("ena_idle_frames", 32'(frames_a - snap), 32'd2);
        chk("ena_idle_busy",   32'(busy_a), 32'd0);

        // ---- A: reset in the middle of bit 5 ----
        ena_a = 1'b1;
        wait_for(0, 1'b1, 500, "rst_scan_start");
        wait_for(3, 1'b1, 200, "rst_bit5_wait");
        #2 rst_a = 1'b1;
        #1;
        chk("rst_mid_cs_n",  32'(cs_n_a),  32'd1);
        chk("rst_mid_sclk",  32'(sclk_a),  32'd0);
        chk("rst_mid_busy",  32'(busy_a),  32'd0);
        chk("rst_mid_valid", 32'(valid_a), 32'd0);
        repeat (2) @(negedge clk);
        snap = valid_cnt_a;
        rst_a = 1'b0;
        wait_for(0, 1'b1, 300, "rst_rescan_start");
        chk("rst_no_valid", 32'(valid_cnt_a - snap), 32'd0);
        wait_for(1, 1'b1, 300, "rst_rescan_valid");
        chk("rst_rescan_ch",    32'(ch_a),     32'd0);
        chk("rst_rescan_data",  32'(sample_a), 32'hA5);
        chk("rst_rescan_rises", 32'(rises_last_a), 32'd9);

        // ---- B: average of 10,11,12,13 on ch0 (ch1 held at 0x20) ----
        val_b1 = 8'h20;
        ena_b  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            val_b0 = 8'(10 + i);
            wait_for(2, 1'b1, 500, "b_scan_start");
            wait_for(2, 1'b0, 500, "b_scan_end");
        end
        chk("b_no_early_out", 32'(xfer_b), 32'd0);
        val_b0 = 8'd13;
        wait_for(2, 1'b1, 500, "b_scan_start");
        wait_for(2, 1'b0, 500, "b_scan_end");
        repeat (2) @(negedge clk);
        chk("b_xfer2",  32'(xfer_b),    32'd2);
        chk("b_avg_ch0", 32'(cap_ch[0]), 32'd0);
        chk("b_avg_d0",  32'(cap_d[0]),  32'h0B);
        chk("b_avg_ch1", 32'(cap_ch[1]), 32'd1);
        chk("b_avg_d1",  32'(cap_d[1]),  32'h20);

        // ---- B: four full-scale conversions must not wrap ----
        val_b0 = 8'hFF;
        val_b1 = 8'h03;
        for (int i = 0; i < 4; i++) begin
            wait_for(2, 1'b1, 500, "b_ff_start");
            wait_for(2, 1'b0, 500, "b_ff_end");
        end
        repeat (2) @(negedge clk);
        chk("b_xfer4",  32'(xfer_b),    32'd4);
        chk("b_ff_ch",  32'(cap_ch[2]), 32'd0);
        chk("b_ff_d",   32'(cap_d[2]),  32'hFF);
        chk("b_03_d",   32'(cap_d[3]),  32'h03);
        chk("b_ovr",    32'(ovr_b),     32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
